// File: rtl/r32_mem_pkg.sv
// rtl/r32_mem_pkg.sv - shared types for the R32 data-port arbiter
package r32_mem_pkg;

  // Transaction phase of the shared memory data port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Index of a requesting master (0 = core load/store, 1 = debug/DMA)
  typedef logic grant_id_t;

  // Request captured at acceptance and replayed to the memory
  typedef struct packed {
    logic        rw;
    logic [31:0] address;
    logic [31:0] data;
    logic [3:0]  strobes;
    logic        bad;
  } req_t;

  // Byte address to word address conversion
  localparam int WORD_SHIFT = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way grant with round-robin or fixed priority
module rr_arbiter2
  import r32_mem_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       grant_valid,
  output grant_id_t  grant_id
);

  // Master favoured on a tie; starts at master 0
  grant_id_t prio;

  // Pick the winner: a lone requester always wins, ties go to prio
  always_comb begin
    grant_valid = |req;
    if (req == 2'b11) begin
      grant_id = ROUND_ROBIN ? prio : 1'b0;
    end else begin
      grant_id = req[1];
    end
  end

  // Hand priority to the other master whenever a grant is consumed
  always_ff @(posedge clk) begin
    if (!resetn) begin
      prio <= 1'b0;
    end else if (advance && grant_valid) begin
      prio <= ~grant_id;
    end
  end

endmodule

// File: rtl/data_port_arbiter.sv
// rtl/data_port_arbiter.sv - shares the ROM_RAM data port between two masters
module data_port_arbiter
  import r32_mem_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter logic [31:0] ADDR_LIMIT  = 32'h0000_4000
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_m0_valid,
  output logic        o_m0_ready,
  input  logic        i_m0_rw,
  input  logic [31:0] i_m0_address,
  input  logic [31:0] i_m0_data,
  input  logic [3:0]  i_m0_strobes,
  output logic [31:0] o_m0_rdata,
  output logic        o_m0_done,
  output logic        o_m0_error,
  input  logic        i_m1_valid,
  output logic        o_m1_ready,
  input  logic        i_m1_rw,
  input  logic [31:0] i_m1_address,
  input  logic [31:0] i_m1_data,
  input  logic [3:0]  i_m1_strobes,
  output logic [31:0] o_m1_rdata,
  output logic        o_m1_done,
  output logic        o_m1_error,
  output logic        o_mem_rw,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_data,
  output logic [3:0]  o_mem_strobes,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_error
);

  state_t      state;
  state_t      state_next;
  req_t        lat;
  grant_id_t   gid;
  logic        arb_valid;
  grant_id_t   arb_id;
  logic        accept;
  logic        sel_rw;
  logic [31:0] sel_address;
  logic [31:0] sel_data;
  logic [3:0]  sel_strobes;
  logic [31:0] resp_data;
  logic        resp_error;

  // A new request can be taken whenever the port is not mid-issue
  assign accept = i_reset && (state != ISSUE) && arb_valid;

  rr_arbiter2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_arb (
    .clk         (i_clock),
    .resetn      (i_reset),
    .req         ({i_m1_valid, i_m0_valid}),
    .advance     (accept),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  // Steer the winning master's request onto the capture path
  always_comb begin
    if (arb_id == 1'b1) begin
      sel_rw      = i_m1_rw;
      sel_address = i_m1_address;
      sel_data    = i_m1_data;
      sel_strobes = i_m1_strobes;
    end else begin
      sel_rw      = i_m0_rw;
      sel_address = i_m0_address;
      sel_data    = i_m0_data;
      sel_strobes = i_m0_strobes;
    end
  end

  // Capture the accepted request and flag misaligned or out-of-range addresses
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      lat <= '0;
      gid <= 1'b0;
    end else if (accept) begin
      lat.rw      <= sel_rw;
      lat.address <= sel_address;
      lat.data    <= sel_data;
      lat.strobes <= sel_strobes;
      lat.bad     <= (sel_address[1:0] != 2'b00) || (sel_address >= ADDR_LIMIT);
      gid         <= arb_id;
    end
  end

  // State register
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: issue follows every accept, response always follows issue
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? ISSUE : IDLE;
      ISSUE:   state_next = RESP;
      RESP:    state_next = accept ? ISSUE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: ready from the arbiter, memory drive in ISSUE, response in RESP
  always_comb begin
    o_m0_ready    = accept && (arb_id == 1'b0);
    o_m1_ready    = accept && (arb_id == 1'b1);
    o_mem_rw      = (state == ISSUE) && lat.rw && !lat.bad && i_reset;
    o_mem_strobes = ((state == ISSUE) && !lat.bad) ? lat.strobes : 4'b0000;
    o_mem_address = lat.address >> WORD_SHIFT;
    o_mem_data    = lat.data;
    resp_data     = (lat.rw || lat.bad) ? 32'h0 : i_mem_data;
    resp_error    = i_mem_error || lat.bad;
    o_m0_done     = 1'b0;
    o_m0_error    = 1'b0;
    o_m0_rdata    = 32'h0;
    o_m1_done     = 1'b0;
    o_m1_error    = 1'b0;
    o_m1_rdata    = 32'h0;
    if (state == RESP) begin
      if (gid == 1'b1) begin
        o_m1_done  = 1'b1;
        o_m1_error = resp_error;
        o_m1_rdata = resp_data;
      end else begin
        o_m0_done  = 1'b1;
        o_m0_error = resp_error;
        o_m0_rdata = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_data_port_arbiter.sv
// tb/tb_data_port_arbiter.sv - scoreboard bench for data_port_arbiter
module tb_data_port_arbiter;

  localparam bit          RR    = 1'b1;
  localparam logic [31:0] LIMIT = 32'h0000_4000;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_m0_valid = 1'b0, i_m1_valid = 1'b0;
  logic        i_m0_rw = 1'b0, i_m1_rw = 1'b0;
  logic [31:0] i_m0_address = '0, i_m1_address = '0;
  logic [31:0] i_m0_data = '0, i_m1_data = '0;
  logic [3:0]  i_m0_strobes = '0, i_m1_strobes = '0;
  logic        o_m0_ready, o_m1_ready, o_m0_done, o_m1_done, o_m0_error, o_m1_error;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic        o_mem_rw;
  logic [31:0] o_mem_address, o_mem_data;
  logic [3:0]  o_mem_strobes;
  logic [31:0] i_mem_data;
  logic        i_mem_error;

  always #5 clk = ~clk;

  data_port_arbiter #(.ROUND_ROBIN(RR), .ADDR_LIMIT(LIMIT)) dut (
    .i_clock(clk), .i_reset(i_reset),
    .i_m0_valid(i_m0_valid), .o_m0_ready(o_m0_ready), .i_m0_rw(i_m0_rw),
    .i_m0_address(i_m0_address), .i_m0_data(i_m0_data), .i_m0_strobes(i_m0_strobes),
    .o_m0_rdata(o_m0_rdata), .o_m0_done(o_m0_done), .o_m0_error(o_m0_error),
    .i_m1_valid(i_m1_valid), .o_m1_ready(o_m1_ready), .i_m1_rw(i_m1_rw),
    .i_m1_address(i_m1_address), .i_m1_data(i_m1_data), .i_m1_strobes(i_m1_strobes),
    .o_m1_rdata(o_m1_rdata), .o_m1_done(o_m1_done), .o_m1_error(o_m1_error),
    .o_mem_rw(o_mem_rw), .o_mem_address(o_mem_address), .o_mem_data(o_mem_data),
    .o_mem_strobes(o_mem_strobes), .i_mem_data(i_mem_data), .i_mem_error(i_mem_error)
  );

  typedef struct { bit rw; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } mreq_t;
  typedef struct { int due; bit m; logic [31:0] rdata; bit err; } rsp_t;
  typedef struct { int due; bit rw; logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } mexp_t;

  mreq_t       mq0[$], mq1[$];
  rsp_t        rsp_q[$];
  mexp_t       mem_q[$];
  bit          grant_log[$];
  logic [31:0] ref_mem [0:4095];
  logic [31:0] mem [0:4095];
  bit          mem_ready = 1'b0;
  int          checks = 0, failures = 0, cyc = 0;
  bit          mon_en = 1'b0, eager = 1'b1;
  bit          held0 = 1'b0, held1 = 1'b0;
  bit          acc_prev = 1'b0, prio_m1 = 1'b0;
  bit          last_wr = 1'b0;
  logic [11:0] last_idx = '0;
  logic [31:0] last_old = '0;

  function automatic logic [31:0] seed(input int i);
    logic [31:0] x;
    x = i;
    return (x * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Words 0xFF0..0xFFF of the memory report an access error
  function automatic bit poisoned(input logic [31:0] w);
    return w[31:4] == 28'h00000FF;
  endfunction

  // Memory environment: one-cycle synchronous RAM with byte enables
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= seed(i);
      mem_ready <= 1'b1;
    end else if (o_mem_rw) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_strobes[b]) mem[o_mem_address[11:0]][8*b +: 8] <= o_mem_data[8*b +: 8];
    end
    i_mem_data  <= mem[o_mem_address[11:0]];
    i_mem_error <= poisoned(o_mem_address);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares DUT responses and memory drive against queued expectations
  always @(negedge clk) begin : monitor
    rsp_t  r;
    mexp_t e;
    bit    hit;
    if (mon_en) begin
      while (rsp_q.size() > 0 && rsp_q[0].due < cyc) begin
        chk("rsp_due", cyc, rsp_q[0].due);
        void'(rsp_q.pop_front());
      end
      hit = rsp_q.size() > 0 && rsp_q[0].due == cyc;
      if (hit) begin
        r = rsp_q.pop_front();
        chk("done",        r.m ? o_m1_done  : o_m0_done,  1);
        chk("rdata",       r.m ? o_m1_rdata : o_m0_rdata, r.rdata);
        chk("error",       r.m ? o_m1_error : o_m0_error, r.err);
        chk("other_done",  r.m ? o_m0_done  : o_m1_done,  0);
        chk("other_rdata", r.m ? o_m0_rdata : o_m1_rdata, 0);
        chk("other_error", r.m ? o_m0_error : o_m1_error, 0);
      end else begin
        chk("idle_done0", o_m0_done, 0);
        chk("idle_done1", o_m1_done, 0);
      end
      while (mem_q.size() > 0 && mem_q[0].due < cyc) begin
        chk("mem_due", cyc, mem_q[0].due);
        void'(mem_q.pop_front());
      end
      hit = mem_q.size() > 0 && mem_q[0].due == cyc;
      if (hit) begin
        e = mem_q.pop_front();
        chk("mem_rw",   o_mem_rw, e.rw);
        chk("mem_addr", o_mem_address, e.addr);
        chk("mem_strb", o_mem_strobes, e.strb);
        if (e.rw) chk("mem_data", o_mem_data, e.data);
      end else begin
        chk("mem_rw_idle",   o_mem_rw, 0);
        chk("mem_strb_idle", o_mem_strobes, 0);
      end
    end
  end

  // Reference model of one accepted transaction: memory effect and expected reply
  task automatic accept_model(input bit m, input mreq_t q);
    bit          bad;
    logic [31:0] word;
    mexp_t       e;
    rsp_t        r;
    bad    = (q.addr % 4 != 0) || (q.addr >= LIMIT);
    word   = q.addr / 4;
    e.due  = cyc + 1; e.rw = q.rw && !bad; e.addr = word; e.data = q.data;
    e.strb = bad ? 4'b0000 : q.strb;
    mem_q.push_back(e);
    r.due   = cyc + 2; r.m = m;
    r.rdata = (!q.rw && !bad) ? ref_mem[word[11:0]] : 32'h0;
    r.err   = bad || poisoned(word);
    rsp_q.push_back(r);
    last_wr = q.rw && !bad;
    if (last_wr) begin
      last_idx = word[11:0];
      last_old = ref_mem[last_idx];
      for (int b = 0; b < 4; b++)
        if (q.strb[b]) ref_mem[last_idx][8*b +: 8] = q.data[8*b +: 8];
    end
  endtask

  task automatic push(input bit m, input bit rw, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mreq_t q;
    q.rw = rw; q.addr = a; q.data = d; q.strb = s;
    if (m) mq1.push_back(q); else mq0.push_back(q);
  endtask

  // One clock of stimulus; valid is held until the master is accepted
  task automatic step();
    bit v0, v1, w, r0e, r1e;
    mreq_t q;
    @(posedge clk); #1;
    v0 = mq0.size() > 0 && (eager || held0 || $urandom_range(3) != 0);
    v1 = mq1.size() > 0 && (eager || held1 || $urandom_range(3) != 0);
    i_m0_valid = v0; i_m1_valid = v1;
    if (v0) begin i_m0_rw = mq0[0].rw; i_m0_address = mq0[0].addr; i_m0_data = mq0[0].data; i_m0_strobes = mq0[0].strb; end
    else begin i_m0_rw = 0; i_m0_address = '0; i_m0_data = '0; i_m0_strobes = '0; end
    if (v1) begin i_m1_rw = mq1[0].rw; i_m1_address = mq1[0].addr; i_m1_data = mq1[0].data; i_m1_strobes = mq1[0].strb; end
    else begin i_m1_rw = 0; i_m1_address = '0; i_m1_data = '0; i_m1_strobes = '0; end
    @(negedge clk);
    w   = (v0 && v1) ? (RR ? prio_m1 : 1'b0) : v1;
    r0e = !acc_prev && v0 && !w;
    r1e = !acc_prev && v1 && w;
    chk("m0_ready", o_m0_ready, r0e);
    chk("m1_ready", o_m1_ready, r1e);
    held0 = v0 && !r0e;
    held1 = v1 && !r1e;
    if (r0e || r1e) begin
      q = w ? mq1.pop_front() : mq0.pop_front();
      accept_model(w, q);
      grant_log.push_back(w);
      prio_m1  = !w;
      acc_prev = 1'b1;
    end else begin
      acc_prev = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((mq0.size() > 0 || mq1.size() > 0 || rsp_q.size() > 0) && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) chk("drain_timeout", n, 0);
  endtask

  // Reset for one edge; an in-flight transaction is dropped and its write undone
  task automatic do_reset();
    mexp_t e;
    @(posedge clk); #1;
    i_reset = 1'b0; i_m0_valid = 1'b0; i_m1_valid = 1'b0;
    held0 = 1'b0; held1 = 1'b0;
    if (acc_prev) begin
      void'(rsp_q.pop_back());
      e = mem_q.pop_back();
      e.rw = 1'b0;
      mem_q.push_back(e);
      if (last_wr) ref_mem[last_idx] = last_old;
    end
    @(negedge clk);
    chk("rst_ready0", o_m0_ready, 0);
    chk("rst_ready1", o_m1_ready, 0);
    @(posedge clk); #1;
    chk("rst_mem_addr", o_mem_address, 0);
    chk("rst_mem_data", o_mem_data, 0);
    chk("rst_mem_rw",   o_mem_rw, 0);
    chk("rst_mem_strb", o_mem_strobes, 0);
    chk("rst_outs",     {o_m0_done, o_m1_done, o_m0_error, o_m1_error, o_m0_ready, o_m1_ready}, 0);
    chk("rst_rdata",    o_m0_rdata | o_m1_rdata, 0);
    i_reset  = 1'b1;
    acc_prev = 1'b0; prio_m1 = 1'b0; last_wr = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    int sel;
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed(i);
    do_reset();
    mon_en = 1'b1;

    push(0, 1, 32'h10, 32'hDEADBEEF, 4'hF); drain();
    push(0, 0, 32'h10, 32'h0, 4'h0);        drain();

    push(1, 1, 32'h20, 32'h0000_00AB, 4'b0001); drain();
    push(0, 0, 32'h20, 32'h0, 4'h0);            drain();

    do_reset();
    grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      push(0, 0, 32'h40 + 8 * i, 0, 0);
      push(1, 0, 32'h44 + 8 * i, 0, 0);
    end
    drain();
    chk("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      chk("grant_order", grant_log[i], RR ? (i % 2) : (i >= 2));

    push(0, 1, LIMIT, 32'h1111_2222, 4'hF);
    push(0, 0, 32'h13, 32'h0, 4'h0);
    drain();
    push(0, 0, 32'h0, 32'h0, 4'h0);
    push(0, 0, LIMIT - 4, 32'h0, 4'h0);
    drain();

    push(1, 0, 32'h3FC4, 32'h0, 4'h0);
    push(0, 0, 32'h8, 32'h0, 4'h0);
    drain();

    push(1, 1, 32'h24, 32'hFFFF_FFFF, 4'h0); drain();
    push(0, 0, 32'h24, 32'h0, 4'h0);        drain();

    push(0, 1, 32'h50, 32'h1234_5678, 4'hF);
    n = 0;
    while (!acc_prev && n < 50) begin step(); n++; end
    if (n >= 50) chk("accept_timeout", n, 0);
    do_reset();
    push(0, 0, 32'h50, 32'h0, 4'h0); drain();

    eager = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(2) == 0) begin
        sel = $urandom_range(9);
        if (sel < 6)       a = 4 * $urandom_range(63);
        else if (sel < 8)  a = 32'h3F80 + 4 * $urandom_range(31);
        else if (sel == 8) a = 4 * $urandom_range(63) + $urandom_range(3, 1);
        else               a = LIMIT + 4 * $urandom_range(255);
        if ($urandom_range(1) == 0) begin
          if (mq0.size() < 3) push(0, $urandom_range(1) == 1, a, $urandom, 4'($urandom_range(15)));
        end else begin
          if (mq1.size() < 3) push(1, $urandom_range(1) == 1, a, $urandom, 4'($urandom_range(15)));
        end
      end
      step();
    end
    drain();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
